// File: rtl/level_column_streamer_if.sv
// Bundle between the column streamer, the level ROM and the scroll/block-array logic.
// master: the streamer itself; slave: the ROM plus the scroll logic around it.
interface level_column_streamer_if #(
   parameter int ROWS    = 10,
   parameter int BLOCK_W = 3,
   parameter int ADDR_W  = 10
);
   logic                      scroll_req;
   logic [BLOCK_W-1:0]        rom_data;
   logic [ADDR_W-1:0]         rom_addr;
   logic                      Shift;
   logic [ROWS*BLOCK_W-1:0]   new_block_id;
   logic [ADDR_W-1:0]         col_idx;
   logic                      init_done;
   logic                      level_end;
   logic                      scroll_overrun;

   modport master (
      input  scroll_req, rom_data,
      output rom_addr, Shift, new_block_id, col_idx, init_done, level_end, scroll_overrun
   );

   modport slave (
      output scroll_req, rom_data,
      input  rom_addr, Shift, new_block_id, col_idx, init_done, level_end, scroll_overrun
   );
endinterface

// File: rtl/level_column_streamer.sv
// Streams level columns from ROM into the scrolling block array: preloads a screen, then one column per scroll_req.
// Optional macro LEVEL_WRAP_EN: the level loops back to column 0 instead of stopping at the end.
module level_column_streamer #(
   parameter int ROWS        = 10,
   parameter int BLOCK_W     = 3,
   parameter int SCREEN_COLS = 10,
   parameter int LEVEL_COLS  = 64,
   parameter int ADDR_W      = 10
) (
   input  logic                   Clk,
   input  logic                   Reset_n,
   level_column_streamer_if.master bus
);
   localparam int K_W   = $clog2(ROWS + 1);
   localparam int P_W   = $clog2(SCREEN_COLS + 1);
   localparam int COL_W = ROWS * BLOCK_W;
`ifdef LEVEL_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   typedef enum logic [1:0] {S_FETCH, S_READY, S_SHIFT, S_END} state_t;

   state_t              state_reg, state_next;
   logic [K_W-1:0]      k_reg, k_next;
   logic [ADDR_W-1:0]   col_reg, col_next;
   logic [ADDR_W-1:0]   base_reg, base_next;
   logic [ADDR_W-1:0]   rom_addr_c;
   logic [P_W-1:0]      preload_reg, preload_next;
   logic                pending_reg, pending_next;
   logic                init_done_reg, init_done_next;
   logic                overrun_reg, overrun_next;
   logic                queue_req;
   logic                preload_done;
   logic                last_col;
   logic                capture_last;
   logic [BLOCK_W-1:0]  row_buf [ROWS-1];
   logic [COL_W-1:0]    assembled;
   logic [COL_W-1:0]    column_reg;

   assign preload_done = (preload_reg == P_W'(SCREEN_COLS));
   assign last_col     = (col_reg == ADDR_W'(LEVEL_COLS - 1));
   assign capture_last = (state_reg == S_FETCH) && (k_reg == K_W'(ROWS));

   // Rows 0..ROWS-2 are staged; the top row comes straight off the ROM so the
   // whole column lands in column_reg on the final capture cycle.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < ROWS - 1; i++) row_buf[i] <= '0;
      end else if (state_reg == S_FETCH) begin
         for (int i = 0; i < ROWS - 1; i++) begin
            if (k_reg == K_W'(i + 1)) row_buf[i] <= bus.rom_data;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < ROWS - 1; gi++) begin : g_pack
         assign assembled[gi*BLOCK_W +: BLOCK_W] = row_buf[gi];
      end
   endgenerate
   assign assembled[(ROWS-1)*BLOCK_W +: BLOCK_W] = bus.rom_data;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) column_reg <= '0;
      else if (capture_last) column_reg <= assembled;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg     <= S_FETCH;
         k_reg         <= '0;
         col_reg       <= '0;
         base_reg      <= '0;
         preload_reg   <= '0;
         pending_reg   <= 1'b0;
         init_done_reg <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         k_reg         <= k_next;
         col_reg       <= col_next;
         base_reg      <= base_next;
         preload_reg   <= preload_next;
         pending_reg   <= pending_next;
         init_done_reg <= init_done_next;
         overrun_reg   <= overrun_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      k_next         = k_reg;
      col_next       = col_reg;
      base_next      = base_reg;
      preload_next   = preload_reg;
      pending_next   = pending_reg;
      init_done_next = init_done_reg;
      overrun_next   = 1'b0;
      queue_req      = 1'b0;
      rom_addr_c     = base_reg + ADDR_W'(k_reg);

      case (state_reg)
         S_FETCH: begin
            queue_req = bus.scroll_req;
            if (k_reg == K_W'(ROWS)) state_next = S_READY;
            else                     k_next     = k_reg + K_W'(1);
         end

         S_READY: begin
            // A request here is consumed directly only when nothing else is owed.
            queue_req = bus.scroll_req && (!preload_done || pending_reg);
            if (!preload_done || pending_reg || bus.scroll_req) state_next = S_SHIFT;
         end

         S_SHIFT: begin
            // Row 0 of the next column is addressed during the strobe, so the
            // following fetch resumes at k=1 and columns stay ROWS+2 cycles apart.
            k_next = K_W'(1);
            if (preload_done) begin
               pending_next = bus.scroll_req;
            end else begin
               queue_req    = bus.scroll_req;
               preload_next = preload_reg + P_W'(1);
            end
            if (preload_reg >= P_W'(SCREEN_COLS - 1) || last_col) init_done_next = 1'b1;
            if (!last_col) begin
               col_next   = col_reg + ADDR_W'(1);
               base_next  = base_reg + ADDR_W'(ROWS);
               state_next = S_FETCH;
            end else if (WRAP) begin
               col_next   = '0;
               base_next  = '0;
               state_next = S_FETCH;
            end else begin
               state_next = S_END;
            end
            rom_addr_c = base_next;
         end

         S_END: begin
         end

         default: state_next = S_FETCH;
      endcase

      if (queue_req) begin
         if (pending_reg) overrun_next = 1'b1;
         else             pending_next = 1'b1;
      end
   end

   assign bus.rom_addr       = rom_addr_c;
   assign bus.Shift          = (state_reg == S_SHIFT);
   assign bus.new_block_id   = column_reg;
   assign bus.col_idx        = col_reg;
   assign bus.init_done      = init_done_reg;
   assign bus.level_end      = (state_reg == S_END);
   assign bus.scroll_overrun = overrun_reg;
endmodule
